// File: rtl/mem_arb_pkg.sv
// Shared state and owner types for the fetch/LSU unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and LSU onto one single-port memory, one transaction in flight, bounded data priority.
// Latency: handshake c0, mem_en c1, response c1+MEM_LAT, next grant possible c2+MEM_LAT.
// Backpressure: readies only in IDLE for the granted port; responses are 1-cycle pulses with no backpressure.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_D_BURST + 1);
    localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_D_BURST);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    arb_state_e        state_q;
    arb_state_e        state_d;
    arb_owner_e        owner_q;
    req_t              req_q;
    logic [CNT_W-1:0]  d_cnt_q;
    logic [LAT_W-1:0]  lat_q;

    logic              grant_d;
    logic              grant_if;
    logic              hs;

    // Data keeps priority until it has taken MAX_D_BURST grants in a row over a waiting fetch.
    always_comb begin
        grant_d  = d_req_valid && (!if_req_valid || (d_cnt_q < CNT_MAX));
        grant_if = if_req_valid && !grant_d;
    end

    assign hs = (state_q == IDLE) && (grant_d || grant_if);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            req_q   <= '0;
            d_cnt_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                if (grant_d) begin
                    owner_q <= OWN_D;
                    req_q   <= '{addr: d_addr, we: d_we, be: d_be, wdata: d_wdata};
                    d_cnt_q <= (d_cnt_q == CNT_MAX) ? d_cnt_q : d_cnt_q + 1'b1;
                end else begin
                    owner_q <= OWN_IF;
                    req_q   <= '{addr: if_addr, we: 1'b0, be: '1, wdata: '0};
                    d_cnt_q <= '0;
                end
            end
            // Counter preloads on the issue cycle so WAIT lasts exactly MEM_LAT-1 cycles.
            if (state_q == ISSUE) begin
                lat_q <= LAT_LOAD;
            end else if ((state_q == WAIT) && (lat_q != '0)) begin
                lat_q <= lat_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_d || grant_if) state_d = ISSUE;
            ISSUE:   state_d = (MEM_LAT == 1) ? RESP : WAIT;
            WAIT:    if (lat_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        if_rdata     = '0;
        d_rsp_valid  = 1'b0;
        d_rdata      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if_req_ready = grant_if;
                    d_req_ready  = grant_d;
                end
                ISSUE: begin
                    mem_en    = 1'b1;
                    mem_we    = req_q.we;
                    mem_be    = req_q.be;
                    mem_addr  = req_q.addr;
                    mem_wdata = req_q.wdata;
                end
                RESP: begin
                    if (owner_q == OWN_D) begin
                        d_rsp_valid = 1'b1;
                        d_rdata     = req_q.we ? '0 : mem_rdata;
                    end else begin
                        if_rsp_valid = 1'b1;
                        if_rdata     = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances side by side.
// Latency: outputs are sampled 1 time unit after each falling edge.
// Backpressure: requests are held until their handshake; responses are always accepted.
module tb_mem_arbiter;

    localparam int MAXB = 4;

    typedef struct packed {
        logic        ifr;
        logic        dr;
        logic        men;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        ifrsp;
        logic [31:0] ifrd;
        logic        drsp;
        logic [31:0] drd;
    } out_t;

    typedef struct packed {
        logic        ifv;
        logic [31:0] ifa;
        logic        dv;
        logic [31:0] da;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwd;
    } in_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [2];
    logic        if_req_valid [2];
    logic [31:0] if_addr      [2];
    logic        d_req_valid  [2];
    logic [31:0] d_addr       [2];
    logic        d_we         [2];
    logic [3:0]  d_be         [2];
    logic [31:0] d_wdata      [2];
    logic [31:0] rd_q         [2];

    wire         if_req_ready [2];
    wire         if_rsp_valid [2];
    wire  [31:0] if_rdata     [2];
    wire         d_req_ready  [2];
    wire         d_rsp_valid  [2];
    wire  [31:0] d_rdata      [2];
    wire         mem_en       [2];
    wire         mem_we       [2];
    wire  [3:0]  mem_be       [2];
    wire  [31:0] mem_addr     [2];
    wire  [31:0] mem_wdata    [2];
    wire  [31:0] mem_rdata    [2];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT((g == 0) ? 1 : 3), .MAX_D_BURST(MAXB)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .if_req_valid(if_req_valid[g]), .if_req_ready(if_req_ready[g]), .if_addr(if_addr[g]),
            .if_rsp_valid(if_rsp_valid[g]), .if_rdata(if_rdata[g]),
            .d_req_valid(d_req_valid[g]), .d_req_ready(d_req_ready[g]), .d_addr(d_addr[g]),
            .d_we(d_we[g]), .d_be(d_be[g]), .d_wdata(d_wdata[g]),
            .d_rsp_valid(d_rsp_valid[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = rd_q[g];
    end

    // Memory contents: untouched words read back a fixed pattern.
    bit [31:0] mem [2][256];
    bit        wr  [2][256];

    function automatic logic [31:0] init_val(input int idx);
        case (idx)
            4:       return 32'h0050_0093;
            32'h40:  return 32'hAABB_CCDD;
            32'h80:  return 32'hCAFE_F00D;
            default: return 32'h1357_0000 ^ (32'(idx) * 32'h0001_0203);
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input int k, input int idx);
        return wr[k][idx] ? mem[k][idx] : init_val(idx);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k]) begin
                if (mem_we[k]) begin
                    mem[k][mem_addr[k][9:2]] <= merge(mem_rd(k, int'(mem_addr[k][9:2])), mem_wdata[k], mem_be[k]);
                    wr[k][mem_addr[k][9:2]]  <= 1'b1;
                end else begin
                    rd_q[k] <= mem_rd(k, int'(mem_addr[k][9:2]));
                end
            end
        end
    end

    function automatic out_t get_out(input int k);
        out_t o;
        o.ifr   = if_req_ready[k];
        o.dr    = d_req_ready[k];
        o.men   = mem_en[k];
        o.mwe   = mem_we[k];
        o.mbe   = mem_be[k];
        o.maddr = mem_addr[k];
        o.mwd   = mem_wdata[k];
        o.ifrsp = if_rsp_valid[k];
        o.ifrd  = if_rdata[k];
        o.drsp  = d_rsp_valid[k];
        o.drd   = d_rdata[k];
        return o;
    endfunction

    function automatic in_t in_req(input logic ifv, input logic [31:0] ifa, input logic dv, input logic [31:0] da,
                                   input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd);
        in_t v;
        v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.da = da; v.dwe = dwe; v.dbe = dbe; v.dwd = dwd;
        return v;
    endfunction

    function automatic out_t o_rdy(input logic ifr, input logic dr);
        out_t o = '0;
        o.ifr = ifr; o.dr = dr;
        return o;
    endfunction

    function automatic out_t o_mem(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        out_t o = '0;
        o.men = 1'b1; o.mwe = we; o.mbe = be; o.maddr = addr; o.mwd = wd;
        return o;
    endfunction

    function automatic out_t o_ifrsp(input logic [31:0] d);
        out_t o = '0;
        o.ifrsp = 1'b1; o.ifrd = d;
        return o;
    endfunction

    function automatic out_t o_drsp(input logic [31:0] d);
        out_t o = '0;
        o.drsp = 1'b1; o.drd = d;
        return o;
    endfunction

    task automatic drive(input int k, input in_t v);
        if_req_valid[k] = v.ifv;
        if_addr[k]      = v.ifa;
        d_req_valid[k]  = v.dv;
        d_addr[k]       = v.da;
        d_we[k]         = v.dwe;
        d_be[k]         = v.dbe;
        d_wdata[k]      = v.dwd;
    endtask

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_order(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        drive(k, '0);
        rst[k] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[k] = 1'b0;
    endtask

    // Reference: arbiter is free from grant+2+lat; data wins unless MAXB data grants in a row beat a waiting fetch.
    task automatic run_random(input int k, input int lat, input int ncyc);
        int          cnt, free_at, iss_at, rsp_at;
        bit          ifp, dp, gi, gd;
        in_t         v;
        out_t        e, iss, rsp, act;
        logic [31:0] refm [16];
        do_reset(k);
        cnt = 0; free_at = 0; iss_at = -1; rsp_at = -1;
        ifp = 1'b0; dp = 1'b0; v = '0; iss = '0; rsp = '0;
        for (int i = 0; i < 16; i++) refm[i] = init_val(i);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!ifp && $urandom_range(0, 2) == 0) begin
                ifp   = 1'b1;
                v.ifa = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp    = 1'b1;
                v.da  = 32'($urandom_range(0, 15)) << 2;
                v.dwe = 1'($urandom_range(0, 1));
                v.dbe = 4'($urandom_range(1, 15));
                v.dwd = $urandom;
            end
            v.ifv = ifp;
            v.dv  = dp;
            drive(k, v);
            #1;
            gd = (c >= free_at) && dp && (!ifp || cnt < MAXB);
            gi = (c >= free_at) && ifp && !gd;
            e  = (c == iss_at) ? iss : (c == rsp_at) ? rsp : '0;
            e.ifr = gi;
            e.dr  = gd;
            act = get_out(k);
            if (c == iss_at && !iss.mwe) act.mwd = '0;
            check($sformatf("rand_lat%0d_c%0d", lat, c), act, e);
            if (gd) begin
                cnt = (cnt < MAXB) ? cnt + 1 : cnt;
                iss = o_mem(v.dwe, v.dbe, v.da, v.dwe ? v.dwd : 32'h0);
                rsp = o_drsp(v.dwe ? 32'h0 : refm[v.da[5:2]]);
                if (v.dwe) refm[v.da[5:2]] = merge(refm[v.da[5:2]], v.dwd, v.dbe);
                dp = 1'b0;
            end else if (gi) begin
                cnt = 0;
                iss = o_mem(1'b0, 4'hF, v.ifa, 32'h0);
                rsp = o_ifrsp(refm[v.ifa[5:2]]);
                ifp = 1'b0;
            end
            if (gd || gi) begin
                iss_at  = c + 1;
                rsp_at  = c + 1 + lat;
                free_at = c + 2 + lat;
            end
        end
        @(negedge clk);
        drive(k, '0);
        repeat (lat + 2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [$];
        out_t        e;
        logic [47:0] order;
        int          grants;

        // Single-cycle-latency vectors: fetch, data-vs-fetch contention, partial write, read-back.
        tbl.push_back('{in_req(1, 32'h10, 0, 0, 0, 0, 0),              o_rdy(1, 0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_mem(0, 4'hF, 32'h10, 0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_ifrsp(32'h0050_0093)});
        tbl.push_back('{in_req(1, 32'h10, 1, 32'h200, 0, 4'hF, 0),     o_rdy(0, 1)});
        tbl.push_back('{in_req(1, 32'h10, 0, 0, 0, 0, 0),              o_mem(0, 4'hF, 32'h200, 0)});
        tbl.push_back('{in_req(1, 32'h10, 0, 0, 0, 0, 0),              o_drsp(32'hCAFE_F00D)});
        tbl.push_back('{in_req(1, 32'h10, 0, 0, 0, 0, 0),              o_rdy(1, 0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_mem(0, 4'hF, 32'h10, 0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_ifrsp(32'h0050_0093)});
        tbl.push_back('{in_req(0, 0, 1, 32'h100, 1, 4'h3, 32'h63),     o_rdy(0, 1)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_mem(1, 4'h3, 32'h100, 32'h63)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_drsp(32'h0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   '0});
        tbl.push_back('{in_req(0, 0, 1, 32'h100, 0, 4'hF, 0),          o_rdy(0, 1)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_mem(0, 4'hF, 32'h100, 0)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   o_drsp(32'hAABB_0063)});
        tbl.push_back('{in_req(0, 0, 0, 0, 0, 0, 0),                   '0});

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            drive(k, in_req(1, 32'h10, 1, 32'h200, 0, 4'hF, 0));
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("reset_hold_%0d", k), get_out(k), '0);
        for (int k = 0; k < 2; k++) drive(k, '0);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("reset_idle_%0d", k), get_out(k), '0);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(0, tbl[k].i);
            #1;
            check($sformatf("vec%0d", k), get_out(0), tbl[k].e);
        end

        // Data held back-to-back with fetch pending: fetch gets in after MAXB data grants.
        do_reset(0);
        order  = '0;
        grants = 0;
        for (int c = 0; c < 80 && grants < 6; c++) begin
            @(negedge clk);
            drive(0, in_req(1, 32'h10, 1, 32'h200, 0, 4'hF, 0));
            #1;
            if (d_req_ready[0]) begin
                order = {order[39:0], 8'h44};
                grants++;
            end else if (if_req_ready[0]) begin
                order = {order[39:0], 8'h49};
                grants++;
            end
        end
        check_order("burst_order", order, "DDDDID");
        @(negedge clk);
        drive(0, '0);
        repeat (3) @(negedge clk);

        // MEM_LAT=3 fetch with a data request waiting behind it.
        @(negedge clk);
        drive(1, in_req(1, 32'h10, 0, 0, 0, 0, 0));
        #1;
        check("lat3_if_grant", get_out(1), o_rdy(1, 0));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(1, in_req(0, 0, 1, 32'h200, 0, 4'hF, 0));
            #1;
            e = (c == 1) ? o_mem(0, 4'hF, 32'h10, 0) : (c == 4) ? o_ifrsp(32'h0050_0093) : (c == 5) ? o_rdy(0, 1) : '0;
            check($sformatf("lat3_c%0d", c), get_out(1), e);
        end
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            drive(1, '0);
            #1;
            e = (c == 6) ? o_mem(0, 4'hF, 32'h200, 0) : (c == 9) ? o_drsp(32'hCAFE_F00D) : '0;
            check($sformatf("lat3_c%0d", c), get_out(1), e);
        end

        // MEM_LAT=3 read abandoned by reset in its WAIT phase, then a clean fetch.
        @(negedge clk);
        drive(1, in_req(0, 0, 1, 32'h200, 0, 4'hF, 0));
        #1;
        check("rst_d_grant", get_out(1), o_rdy(0, 1));
        @(negedge clk);
        drive(1, '0);
        #1;
        check("rst_d_issue", get_out(1), o_mem(0, 4'hF, 32'h200, 0));
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("rst_hold_c2", get_out(1), '0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            rst[1] = 1'b0;
            #1;
            check($sformatf("rst_after_c%0d", c), get_out(1), '0);
        end
        @(negedge clk);
        drive(1, in_req(1, 32'h10, 0, 0, 0, 0, 0));
        #1;
        check("rst_if_grant", get_out(1), o_rdy(1, 0));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(1, '0);
            #1;
            e = (c == 1) ? o_mem(0, 4'hF, 32'h10, 0) : (c == 4) ? o_ifrsp(32'h0050_0093) : '0;
            check($sformatf("rst_if_c%0d", c), get_out(1), e);
        end

        run_random(0, 1, 400);
        run_random(1, 3, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
